// File: rtl/lc3b_seq_alu_pkg.sv
// rtl/lc3b_seq_alu_pkg.sv - shared opcode and state types for the sequential LC-3b ALU
package lc3b_types;

  typedef enum logic [3:0] {
    alu_add     = 4'd0,
    alu_and     = 4'd1,
    alu_not     = 4'd2,
    alu_pass    = 4'd3,
    alu_sll     = 4'd4,
    alu_srl     = 4'd5,
    alu_sra     = 4'd6,
    alu_bitcopy = 4'd7,
    alu_mul     = 4'd8,
    alu_divu    = 4'd9,
    alu_remu    = 4'd10
  } lc3b_aluop;

  typedef enum logic [1:0] {
    s_idle,
    s_iter,
    s_done
  } lc3b_alu_state;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == alu_divu) || (op == alu_remu);
  endfunction

endpackage

// File: rtl/lc3b_seq_alu_if.sv
// rtl/lc3b_seq_alu_if.sv - request/response handshake bundle between control FSM and ALU
interface lc3b_seq_alu_if #(parameter int WIDTH = 16);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] result;
  logic             err_dz;
  logic             err_op;

  modport master (
    output req_valid, op, a, b, resp_ready,
    input  req_ready, resp_valid, result, err_dz, err_op
  );

  modport slave (
    input  req_valid, op, a, b, resp_ready,
    output req_ready, resp_valid, result, err_dz, err_op
  );
endinterface

// File: rtl/lc3b_seq_alu_muldiv_iter.sv
// rtl/lc3b_seq_alu_muldiv_iter.sv - one-bit-per-cycle shift-add multiplier and restoring divider
module lc3b_muldiv_iter
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] quo, dvsr;
  logic [WIDTH:0]   rem;
  logic [WIDTH+1:0] shifted, trial;

  // Two guard bits so a failed trial subtraction shows up as a set MSB.
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial   = shifted - {2'b00, dvsr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      quo    <= '0;
      dvsr   <= '0;
      rem    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
      quo    <= a;
      dvsr   <= b;
      rem    <= '0;
    end else if (step) begin
      if (mode == MODE_MUL) begin
        acc    <= acc + (mplier[0] ? mcand : '0);
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end else if (!trial[WIDTH+1]) begin
        rem <= trial[WIDTH:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted[WIDTH:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign product   = acc;
  assign quotient  = quo;
  assign remainder = rem[WIDTH-1:0];

endmodule

// File: rtl/lc3b_seq_alu.sv
// rtl/lc3b_seq_alu.sv - multi-cycle LC-3b ALU: control FSM, single-cycle ops, output registers
module lc3b_seq_alu
  import lc3b_types::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  lc3b_seq_alu_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  lc3b_alu_state    state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] result_q, alu_y;
  logic             resp_valid_q, err_dz_q, err_op_q;
  logic             dz_y, eop_y;
  logic             accept, iter_start;
  logic [WIDTH-1:0] product, quotient, remainder;
  logic [SHAMT_W-1:0] shamt;

  assign accept     = (state == s_idle) && bus.req_valid;
  assign iter_start = (bus.op == alu_mul) || (is_div_op(bus.op) && (bus.b != '0));

  lc3b_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept && iter_start),
    .step      (state == s_iter),
    .mode      ((op_q == alu_mul) ? MODE_MUL : MODE_DIV),
    .a         (bus.a),
    .b         (bus.b),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_comb begin
    state_n = state;
    case (state)
      s_idle: if (bus.req_valid) state_n = iter_start ? s_iter : s_done;
      s_iter: if (cnt == CNT_W'(1)) state_n = s_done;
      s_done: if (resp_valid_q && bus.resp_ready) state_n = s_idle;
      default: state_n = s_idle;
    endcase
  end

  assign shamt = b_q[SHAMT_W-1:0];

  always_comb begin
    alu_y = '0;
    dz_y  = 1'b0;
    eop_y = 1'b0;
    case (op_q)
      alu_add:     alu_y = a_q + b_q;
      alu_and:     alu_y = a_q & b_q;
      alu_not:     alu_y = ~a_q;
      alu_pass:    alu_y = a_q;
      alu_bitcopy: alu_y = b_q;
      alu_sll:     alu_y = a_q << shamt;
      alu_srl:     alu_y = a_q >> shamt;
      alu_sra:     alu_y = WIDTH'($signed(a_q) >>> shamt);
      alu_mul:     alu_y = product;
      alu_divu: begin
        dz_y  = (b_q == '0);
        alu_y = dz_y ? '1 : quotient;
      end
      alu_remu: begin
        dz_y  = (b_q == '0);
        alu_y = dz_y ? a_q : remainder;
      end
      default:     eop_y = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= s_idle;
      cnt          <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
      err_dz_q     <= 1'b0;
      err_op_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_q <= bus.op;
        a_q  <= bus.a;
        b_q  <= bus.b;
        cnt  <= iter_start ? CNT_W'(WIDTH) : '0;
      end else if (state == s_iter) begin
        cnt <= cnt - CNT_W'(1);
      end
      // First DONE cycle captures the result; the response is presented from the next one.
      if (state == s_done) begin
        if (!resp_valid_q) begin
          resp_valid_q <= 1'b1;
          result_q     <= alu_y;
          err_dz_q     <= dz_y;
          err_op_q     <= eop_y;
        end else if (bus.resp_ready) begin
          resp_valid_q <= 1'b0;
          err_dz_q     <= 1'b0;
          err_op_q     <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready  = (state == s_idle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.result     = result_q;
  assign bus.err_dz     = err_dz_q;
  assign bus.err_op     = err_op_q;

endmodule

// File: tb/tb_lc3b_seq_alu.sv
// tb/tb_lc3b_seq_alu.sv - directed self-checking bench for lc3b_seq_alu at WIDTH=16
module tb_lc3b_seq_alu;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lc3b_seq_alu_if #(.WIDTH(16)) bus ();

  lc3b_seq_alu #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input string tag);
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.req_valid = 1'b1;
    chk({tag, "/req_ready"}, 16'(bus.req_ready), 16'h1);
    tick();
    bus.req_valid = 1'b0;
    chk({tag, "/busy"}, 16'(bus.req_ready), 16'h0);
  endtask

  task automatic wait_resp(input string tag, input int exp_lat);
    int lat = 1;
    tick();
    while (!bus.resp_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, "/latency"}, 16'(lat), 16'(exp_lat));
  endtask

  task automatic take(input string tag, input logic [15:0] res, input logic dz, input logic eop);
    chk({tag, "/result"}, bus.result, res);
    chk({tag, "/err_dz"}, 16'(bus.err_dz), 16'(dz));
    chk({tag, "/err_op"}, 16'(bus.err_op), 16'(eop));
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk({tag, "/resp_clear"}, 16'(bus.resp_valid), 16'h0);
    chk({tag, "/ready_again"}, 16'(bus.req_ready), 16'h1);
    chk({tag, "/flags_clear"}, 16'({bus.err_dz, bus.err_op}), 16'h0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int lat, input logic [15:0] res, input logic dz, input logic eop,
                        input string tag);
    issue(op, a, b, tag);
    wait_resp(tag, lat);
    take(tag, res, dz, eop);
  endtask

  initial begin
    int stale;
    logic [15:0] held;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    bus.op         = '0;
    bus.a          = '0;
    bus.b          = '0;

    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk("reset/req_ready", 16'(bus.req_ready), 16'h1);
    chk("reset/resp_valid", 16'(bus.resp_valid), 16'h0);
    chk("reset/result", bus.result, 16'h0000);
    chk("reset/flags", 16'({bus.err_dz, bus.err_op}), 16'h0);
    tick();

    // Stray resp_ready in IDLE must do nothing.
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("idle_resp_ready/resp_valid", 16'(bus.resp_valid), 16'h0);

    // Back-to-back: the and request is driven immediately after the add handshake edge.
    run_op(alu_add, 16'h7FFF, 16'h0001, 1, 16'h8000, 1'b0, 1'b0, "add");
    run_op(alu_and, 16'hF0F0, 16'h0FF0, 1, 16'h00F0, 1'b0, 1'b0, "and");
    run_op(alu_not, 16'h1234, 16'h0000, 1, 16'hEDCB, 1'b0, 1'b0, "not");
    run_op(alu_pass, 16'hBEEF, 16'h1111, 1, 16'hBEEF, 1'b0, 1'b0, "pass");
    run_op(alu_bitcopy, 16'hBEEF, 16'h1111, 1, 16'h1111, 1'b0, 1'b0, "bitcopy");

    run_op(alu_sra, 16'h8000, 16'h0013, 1, 16'hF000, 1'b0, 1'b0, "sra");
    run_op(alu_srl, 16'h8000, 16'h0013, 1, 16'h1000, 1'b0, 1'b0, "srl");
    run_op(alu_sll, 16'h8000, 16'h0013, 1, 16'h0000, 1'b0, 1'b0, "sll");
    run_op(alu_sll, 16'h0001, 16'h000F, 1, 16'h8000, 1'b0, 1'b0, "sll15");

    run_op(alu_mul, 16'h0123, 16'h0045, 17, 16'h4E6F, 1'b0, 1'b0, "mul");
    run_op(alu_mul, 16'hFFFF, 16'h0002, 17, 16'hFFFE, 1'b0, 1'b0, "mul_wrap");
    run_op(alu_mul, 16'h1234, 16'h0000, 17, 16'h0000, 1'b0, 1'b0, "mul_zero");

    run_op(alu_divu, 16'd100, 16'd7, 17, 16'h000E, 1'b0, 1'b0, "divu");
    run_op(alu_remu, 16'd100, 16'd7, 17, 16'h0002, 1'b0, 1'b0, "remu");
    run_op(alu_divu, 16'hFFFF, 16'h0001, 17, 16'hFFFF, 1'b0, 1'b0, "divu_by1");
    run_op(alu_remu, 16'hFFFF, 16'h8000, 17, 16'h7FFF, 1'b0, 1'b0, "remu_big");

    run_op(alu_divu, 16'h1234, 16'h0000, 1, 16'hFFFF, 1'b1, 1'b0, "divu_dz");
    run_op(alu_remu, 16'h1234, 16'h0000, 1, 16'h1234, 1'b1, 1'b0, "remu_dz");

    run_op(4'd12, 16'h5555, 16'hAAAA, 1, 16'h0000, 1'b0, 1'b1, "illegal12");
    run_op(4'd11, 16'h5555, 16'hAAAA, 1, 16'h0000, 1'b0, 1'b1, "illegal11");

    // Back-pressure with request pulses that must be ignored.
    issue(alu_mul, 16'h0010, 16'h0010, "bp");
    wait_resp("bp", 17);
    held = bus.result;
    chk("bp/value", held, 16'h0100);
    bus.op = alu_add;
    bus.a  = 16'h0001;
    bus.b  = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = i[0];
      tick();
      chk("bp/hold_valid", 16'(bus.resp_valid), 16'h1);
      chk("bp/hold_result", bus.result, 16'h0100);
      chk("bp/hold_ready", 16'(bus.req_ready), 16'h0);
    end
    bus.req_valid = 1'b0;
    take("bp", 16'h0100, 1'b0, 1'b0);
    run_op(alu_add, 16'h0002, 16'h0003, 1, 16'h0005, 1'b0, 1'b0, "after_bp");

    // Reset during the eighth ITER cycle of a multiply.
    issue(alu_mul, 16'h00FF, 16'h00FF, "rst_mid");
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid/resp_valid", 16'(bus.resp_valid), 16'h0);
    chk("rst_mid/req_ready", 16'(bus.req_ready), 16'h1);
    chk("rst_mid/result", bus.result, 16'h0000);
    tick();
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.resp_valid) stale++;
    end
    chk("rst_mid/no_stale", 16'(stale), 16'h0);
    run_op(alu_add, 16'h1000, 16'h0234, 1, 16'h1234, 1'b0, 1'b0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3b_seq_alu.md
# lc3b_seq_alu

Parametrised, multi-cycle successor to the LC-3b datapath ALU. Executes the full `lc3b_aluop` set (add, and, not, pass, shifts, bitcopy) at configurable width and adds iterative unsigned multiply, divide and remainder. Sits between the datapath operand muxes and the register-file/MDR write-back path. The control FSM drives it through a valid/ready request and response handshake.

## Interface
- `WIDTH`, 16: operand and result width; legal values are 4 to 64.
- `SHAMT_W`, `$clog2(WIDTH)`: number of low bits of `b` used as the shift amount.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `op`  in  4  `lc3b_aluop` encoding.
- `a`  in  WIDTH  operand A; dividend for divide ops.
- `b`  in  WIDTH  operand B; shift amount source and divisor.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  registered result.
- `err_dz`  out  1  divide/remainder by zero.
- `err_op`  out  1  illegal opcode (encodings 11–15).

## Operation
- Opcode functions:
  - add: `a+b`, modulo 2^WIDTH.
  - and: `a&b`.
  - not: `~a`.
  - pass: `a`.
  - bitcopy: `b`.
  - sll / srl / sra: `a` shifted by `b[SHAMT_W-1:0]`; sra replicates the MSB.
  - mul (8): low WIDTH bits of `a*b`, by shift-add.
  - divu (9): `a/b`, by restoring division.
  - remu (10): `a%b`, by restoring division.
- FSM states are IDLE, ITER and DONE.
- IDLE:
  - `req_ready=1`.
  - On `req_valid && req_ready`, the unit latches `op`, `a` and `b`.
  - Single-cycle ops and error cases go to DONE.
  - mul, and divu/remu with `b!=0`, go to ITER with the counter loaded to WIDTH.
- ITER:
  - Performs one partial-product or restoring step per cycle and decrements the counter.
  - On the cycle the counter reaches 1, the final step completes and the FSM goes to DONE.
  - `req_valid` is ignored while in ITER.
- DONE:
  - `resp_valid=1`; `result`, `err_dz` and `err_op` stay stable.
  - On `resp_ready`, the FSM returns to IDLE.
- Divide by zero:
  - divu returns all-ones; remu returns `a`.
  - `err_dz=1`. There is no iteration.
- Illegal opcode: `result=0`, `err_op=1`.
- Error flags are valid only while `resp_valid=1`. They clear on the response handshake.
- Internal registers:
  - Counter is `$clog2(WIDTH)+1` bits.
  - mul uses a WIDTH-bit accumulator and shifting copies of `a` and `b`.
  - div uses a WIDTH+1-bit partial remainder and a WIDTH-bit quotient register.

## Timing
- Reset values (`rst_n` low): state IDLE, `req_ready=1`, `resp_valid=0`, `result=0`, `err_dz=0`, `err_op=0`, counter 0.
- Reset mid-operation aborts immediately. No response is produced for the aborted request.
- Request accepted at edge 0 (counted from the accepting edge):
  - Single-cycle ops, error cases and zero divisor: `resp_valid` high after edge 1.
  - mul, divu, remu: `resp_valid` high after edge WIDTH+1.
- Back-pressure: DONE holds for any number of cycles while `resp_ready=0`. Outputs must not change during that time.
- Back-to-back requests:
  - The response handshake at edge N gives IDLE and `req_ready=1` after edge N.
  - The next request can be accepted at edge N+1.
  - There is no same-cycle accept-and-respond.
- `req_ready` is a combinational decode of state only. It must not depend on `req_valid` or `resp_ready`.
- A `resp_ready` that is high outside DONE has no effect.

## Structure
- `lc3b_types` extends `lc3b_aluop` with `alu_mul`, `alu_divu` and `alu_remu`, explicitly valued 8, 9 and 10.
- The FSM state enum (`lc3b_alu_state`) also lives in `lc3b_types`.
- Sub-module `lc3b_muldiv_iter`, parametrised by WIDTH:
  - Contains the iterative datapath: shift-add and restoring step registers.
  - Controlled by `load`, `step` and `mode`.
  - Exposes product, quotient and remainder.
- The top level holds the FSM, the counter, the single-cycle combinational ops and the output registers.

## Test plan
All scenarios use WIDTH=16.
- **Reset values:** hold `rst_n` low for 3 cycles, then release → `req_ready=1`, `resp_valid=0`, `result=0x0000`, no flags.
- **Add:** add `0x7FFF`+`0x0001` → `result=0x8000` with `resp_valid` after edge 1.
- **Back-to-back:** add, then and `0xF0F0&0x0FF0` → second result `0x00F0`, with the second request accepted one cycle after the first handshake.
- **Shifts:** `a=0x8000`, `b=0x0013` → sra `0xF000`, srl `0x1000`, sll `0x0000` (only the low 4 bits of `b` are used, giving a shift of 3).
- **Multiply:** mul `0x0123`×`0x0045` → `0x4E6F`, with `resp_valid` exactly after edge 17.
- **Multiply wrap:** mul `0xFFFF`×`0x0002` → `0xFFFE`.
- **Divide and remainder:** divu 100/7 → `0x000E`; remu → `0x0002`.
- **Zero divisor:** divu `0x1234`/0 → `0xFFFF` with `err_dz=1` after edge 1; remu → `0x1234`.
- **Illegal opcode:** op 12 → `result=0`, `err_op=1`.
- **Back-pressure:** hold `resp_ready=0` for 5 cycles after a mul → `result` stable, `req_ready=0`, and `req_valid` pulses ignored.
- **Reset mid-operation:** assert `rst_n` at ITER cycle 8 of a mul → `resp_valid=0` and `req_ready=1` immediately, and no stale response ever appears.
